cpu_clock_gen: RTL and testbench

Parametrised 6309E clock generator: derives free-running 24/12 MHz outputs and the quadrature E/Q pair from the 48 MHz master clock, with a run-time selectable CPU speed, multi-source wait-state stretching with a timeout, and a programmable MMU strobe. Every register runs on MHZ48; no derived clocks are used as clocks. nE/nQ leave the CPLD active-low and are re-inverted by the external 74HCT04.

---
 rtl/cpu_clock_gen.sv | 89 ++++++++
 tb/tb_cpu_clock_gen.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/cpu_clock_gen.sv
// cpu_clock_gen: 6309E E/Q quadrature generator on the 48 MHz master clock with
// selectable speed, multi-source wait stretching with timeout, and a programmable MMU strobe.
module cpu_clock_gen #(
    parameter int DIV_FAST    = 4,
    parameter int DIV_SLOW    = 8,
    parameter int NWAIT       = 2,
    parameter int MAX_STRETCH = 15,
    parameter int STRB_START  = 0,
    parameter int STRB_LEN    = 4
) (
    input  logic             MHZ48,
    input  logic             nRESET,
    input  logic [NWAIT-1:0] nWAIT,
    input  logic             SLOW,
    input  logic             CLR_TMO,
    output logic             MHZ24,
    output logic             MHZ12,
    output logic             nE,
    output logic             nQ,
    output logic             nSTROBE,
    output logic             CYCLE,
    output logic             STRETCH,
    output logic             WAIT_TMO
);
    localparam int DMAX = DIV_SLOW > DIV_FAST ? DIV_SLOW : DIV_FAST;
    localparam int SW = $clog2(DMAX + 1);
    localparam int CW = MAX_STRETCH > 0 ? $clog2(MAX_STRETCH + 1) : 1;
    logic [1:0]    fcnt, phase, phase_n;
    logic [SW-1:0] sub, sub_n, div;
    logic [CW-1:0] scnt, scnt_n;
    logic [15:0]   t;
    logic          slow_q, sync1, sync2, end_q, q3_end, hold, tmo_set, cyc_n, stretch_n, e_n, q_n, strb_n;

    assign MHZ24 = fcnt[0];
    assign MHZ12 = fcnt[1];
    assign div = slow_q ? SW'(DIV_SLOW) : SW'(DIV_FAST);

    always_ff @(posedge MHZ48 or negedge nRESET)
        if (!nRESET) begin
            fcnt <= '0;
            phase <= '0;
            sub <= '0;
            scnt <= '0;
            slow_q <= 1'b0;
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            nE <= 1'b1;
            nQ <= 1'b1;
            nSTROBE <= 1'b1;
            CYCLE <= 1'b0;
            STRETCH <= 1'b0;
            WAIT_TMO <= 1'b0;
        end else begin
            fcnt <= fcnt + 2'd1;
            phase <= phase_n;
            sub <= sub_n;
            scnt <= scnt_n;
            if (cyc_n) slow_q <= SLOW;
            sync1 <= &nWAIT;
            sync2 <= sync1;
            nE <= ~e_n;
            nQ <= ~q_n;
            nSTROBE <= ~strb_n;
            CYCLE <= cyc_n;
            STRETCH <= stretch_n;
            WAIT_TMO <= tmo_set | (WAIT_TMO & ~CLR_TMO);
        end

    // wait is only sampled at the final edge of Q3; Q3+1 wraps back to Q0
    always_comb begin
        end_q = sub == div - SW'(1);
        q3_end = end_q && phase == 2'd3 && !sync2;
        hold = q3_end && scnt < CW'(MAX_STRETCH);
        tmo_set = q3_end && scnt == CW'(MAX_STRETCH);
        cyc_n = end_q && phase == 2'd3 && !hold;
        sub_n = end_q ? '0 : sub + SW'(1);
        phase_n = end_q && !hold ? phase + 2'd1 : phase;
        scnt_n = cyc_n ? '0 : scnt + CW'(hold);
        stretch_n = end_q ? hold : STRETCH;
    end

    // strobe window test uses wraparound so offsets below STRB_START fall outside
    always_comb begin
        e_n = phase_n[1];
        q_n = phase_n[1] ^ phase_n[0];
        t = 16'(phase) * 16'(div) + 16'(sub);
        strb_n = !phase[1] && (t - 16'(STRB_START)) < 16'(STRB_LEN);
    end
endmodule

// File: tb/tb_cpu_clock_gen.sv
// tb_cpu_clock_gen: randomized per-E-cycle scoreboard; each planned cycle's expected shape is
// queued by the stimulus and checked by a monitor at the next CYCLE pulse.
module tb_cpu_clock_gen;
    localparam int DIV_FAST = 4, DIV_SLOW = 8, NWAIT = 2, MAX_STRETCH = 15, STRB_START = 0, STRB_LEN = 4;
    localparam int TMO = MAX_STRETCH + 1;
    typedef struct {
        int per;
        int eh;
        int qh;
        int sh;
        int sc;
        int sf;
        int tmo;
    } rec_t;
    logic MHZ48 = 0, nRESET = 0, SLOW = 0, CLR_TMO = 0;
    logic [NWAIT-1:0] nWAIT = '1;
    logic MHZ24, MHZ12, nE, nQ, nSTROBE, CYCLE, STRETCH, WAIT_TMO;
    rec_t sb[$];
    rec_t r;
    int tests = 0, fails = 0, ecnt = 0, tmo_exp = 0;
    int per = 0, eh = 0, qh = 0, sh = 0, sc = 0, sf = -1;
    bit d_cur = 0, started = 0, clk_ok = 1;
    int kinds[8] = '{0, 1, 0, TMO, 2, 0, TMO, 3};
    bit slows[8] = '{0, 0, 1, 1, 0, 1, 0, 0};
    bit clrs[8] = '{0, 0, 0, 1, 1, 0, 0, 0};

    cpu_clock_gen #(
        .DIV_FAST(DIV_FAST), .DIV_SLOW(DIV_SLOW), .NWAIT(NWAIT),
        .MAX_STRETCH(MAX_STRETCH), .STRB_START(STRB_START), .STRB_LEN(STRB_LEN)
    ) dut (
        .MHZ48(MHZ48), .nRESET(nRESET), .nWAIT(nWAIT), .SLOW(SLOW), .CLR_TMO(CLR_TMO),
        .MHZ24(MHZ24), .MHZ12(MHZ12), .nE(nE), .nQ(nQ), .nSTROBE(nSTROBE),
        .CYCLE(CYCLE), .STRETCH(STRETCH), .WAIT_TMO(WAIT_TMO)
    );

    always #5 MHZ48 = ~MHZ48;

    task automatic chk(string n, int a, int x);
        tests++;
        if (a != x) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", n, a, x);
        end
    endtask

    // edges since reset release: the free divider must track this regardless of waits or speed
    always @(posedge MHZ48 or negedge nRESET) ecnt <= !nRESET ? 0 : ecnt + 1;

    always @(negedge nRESET) begin
        started = 0;
        sb.delete();
    end

    always @(negedge MHZ48) if (nRESET) begin
        if (CYCLE && started) begin
            chk("sb_pending", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                r = sb.pop_front();
                chk("period", per, r.per);
                chk("e_high", eh, r.eh);
                chk("q_high", qh, r.qh);
                chk("stretch_len", sh, r.sh);
                chk("strobe_len", sc, r.sc);
                chk("strobe_start", sf, r.sf);
                chk("wait_tmo", int'(WAIT_TMO), r.tmo);
                chk("free_clocks", int'(clk_ok), 1);
            end
        end
        if (CYCLE) begin
            started = 1;
            per = 0; eh = 0; qh = 0; sh = 0; sc = 0; sf = -1; clk_ok = 1;
        end
        if (started) begin
            eh += int'(!nE);
            qh += int'(!nQ);
            sh += int'(STRETCH);
            if (!nSTROBE) begin
                if (sf < 0) sf = per;
                sc++;
            end
            if (MHZ24 !== ecnt[0] || MHZ12 !== ecnt[1]) clk_ok = 0;
            per++;
        end
    end

    task automatic reset_seq();
        bit early = 0;
        nRESET = 0;
        nWAIT = '1;
        SLOW = 0;
        CLR_TMO = 0;
        repeat (10) @(negedge MHZ48);
        chk("rst_nE", int'(nE), 1);
        chk("rst_nQ", int'(nQ), 1);
        chk("rst_nSTROBE", int'(nSTROBE), 1);
        chk("rst_CYCLE", int'(CYCLE), 0);
        chk("rst_STRETCH", int'(STRETCH), 0);
        chk("rst_WAIT_TMO", int'(WAIT_TMO), 0);
        chk("rst_MHZ24", int'(MHZ24), 0);
        chk("rst_MHZ12", int'(MHZ12), 0);
        tmo_exp = 0;
        d_cur = 0;
        nRESET = 1;
        for (int e = 1; e <= 16; e++) begin
            @(negedge MHZ48);
            if (e == 3) chk("nq_edge3", int'(nQ), 1);
            if (e == 4) chk("nq_edge4", int'(nQ), 0);
            if (e == 7) chk("ne_edge7", int'(nE), 1);
            if (e == 8) chk("ne_edge8", int'(nE), 0);
            if (e < 16 && CYCLE) early = 1;
        end
        chk("cycle_early", int'(early), 0);
        chk("cycle_first", int'(CYCLE), 1);
    endtask

    // k = number of stretches wanted (TMO = wait held past the limit); rst_s > 0 resets during that stretch
    task automatic run_cycle(int k, bit sn, bit cl, bit ch, int rst_s);
        int d = d_cur ? DIV_SLOW : DIV_FAST;
        int ke = k > MAX_STRETCH ? MAX_STRETCH : k;
        int len = (4 + ke) * d;
        int src = int'($urandom_range(NWAIT - 1, 0));
        int e = 0;
        if (cl) tmo_exp = 0;
        if (k > MAX_STRETCH) tmo_exp = 1;
        if (rst_s == 0) sb.push_back('{len, (2 + ke) * d, 2 * d, ke * d, STRB_LEN, STRB_START + 1, tmo_exp});
        do begin
            @(negedge MHZ48);
            e++;
            if (e == 1 && k > 0) nWAIT[src] = 1'b0;
            if (k == 0 && e == d) nWAIT[src] = 1'b0;
            if (k == 0 && e == 2 * d) nWAIT = '1;
            if (k > 0 && k <= MAX_STRETCH && e == (3 + k) * d) nWAIT = '1;
            if (e == d + 1) begin
                SLOW = sn;
                CLR_TMO = cl;
            end
            if (e == d + 2) CLR_TMO = 0;
            if (k > MAX_STRETCH && ch && e == len - 1) CLR_TMO = 1;
            if (rst_s != 0 && e == (3 + rst_s) * d + 2) begin
                chk("stretch_before_rst", int'(STRETCH), 1);
                #2 nRESET = 0;
                #1;
                chk("midrst_nE", int'(nE), 1);
                chk("midrst_nQ", int'(nQ), 1);
                chk("midrst_nSTROBE", int'(nSTROBE), 1);
                chk("midrst_STRETCH", int'(STRETCH), 0);
                chk("midrst_MHZ24", int'(MHZ24), 0);
                chk("midrst_MHZ12", int'(MHZ12), 0);
                nWAIT = '1;
                CLR_TMO = 0;
                return;
            end
        end while (!CYCLE && e < 400);
        chk("cycle_end_seen", int'(CYCLE), 1);
        nWAIT = '1;
        CLR_TMO = 0;
        d_cur = sn;
    endtask

    initial begin
        reset_seq();
        for (int i = 0; i < 22; i++)
            if (i < 8) run_cycle(kinds[i], slows[i], clrs[i], i == 3, 0);
            else run_cycle($urandom_range(5, 0) == 0 ? TMO : int'($urandom_range(3, 0)),
                           1'($urandom_range(1, 0)), $urandom_range(3, 0) == 0, 1'($urandom_range(1, 0)), 0);
        run_cycle(5, 0, 0, 0, 3);
        reset_seq();
        repeat (2) run_cycle(0, 0, 0, 0, 0);
        repeat (2) @(negedge MHZ48);
        chk("sb_drain", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
